// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter:
// state encodings, frame width and bit-period helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the character source stage
// and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter; flags the last clock of a serial bit.
// Counter is cleared explicitly and never relies on wrap-around.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] clk_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt <= '0;
        end else if (clear) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    assign bit_end = (clk_cnt == LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// All outputs are registered; the byte is captured on the accept edge.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_cpb_check
            $error("uart_tx_fsm: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 clear;
    logic                 bit_end;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx        <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx        <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx;
        busy_d    = busy_q;
        done_d    = 1'b0;
        clear     = 1'b0;
        unique case (state_q)
            IDLE: begin
                clear  = 1'b1;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d = bus.tx_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clear     = 1'b1;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clear = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    clear   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule
